// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg
// Shared definitions for the RAM arbiter and its round-robin picker:
// default bus widths, the maximum requester count, the port-id width,
// the response-pipeline entry type and the round-robin pointer step.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
    localparam int MAX_PORTS  = 4;
    localparam int PID_W      = 2;

    // One response-pipeline stage: a read in flight and the port it belongs to.
    typedef struct packed {
        logic             vld;
        logic [PID_W-1:0] id;
    } rsp_t;

    // Pointer value after a grant to 'cur': the port just above it, wrapping.
    function automatic logic [PID_W-1:0] rr_next(input logic [PID_W-1:0] cur,
                                                 input int               nports);
        logic [PID_W-1:0] nxt;
        if (int'(cur) >= nports - 1) begin
            nxt = PID_W'(0);
        end else begin
            nxt = cur + PID_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Requester-side bus of the RAM arbiter.
//   req    per-port level request
//   we     per-port command (1 = write, 0 = read)
//   addr   per-port address, port i at [i*ADDR_W +: ADDR_W]
//   wdata  per-port write data, port i at [i*DATA_W +: DATA_W]
//   gnt    one-hot accept pulse, same cycle as the request
//   rvalid one-hot read-data-valid
//   rdata  shared read data, meaningful only for the port with rvalid high
// master: the requesters; slave: the arbiter.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [NPORTS-1:0]        req;
    logic [NPORTS-1:0]        we;
    logic [NPORTS*ADDR_W-1:0] addr;
    logic [NPORTS*DATA_W-1:0] wdata;
    logic [NPORTS-1:0]        gnt;
    logic [NPORTS-1:0]        rvalid;
    logic [DATA_W-1:0]        rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker
// Purely combinational round-robin picker, reusable by any shared-resource
// arbiter. Starting at ptr_i and searching upward modulo NPORTS, the first
// requesting port wins.
//   req_i    per-port request
//   ptr_i    current highest-priority port
//   gnt_o    one-hot winner (all zero when nobody requests)
//   winner_o encoded winner (0 when nobody requests)
//   valid_o  at least one port requests
module rr_picker
    import ram_arbiter_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [PID_W-1:0]  ptr_i,
    output logic [NPORTS-1:0] gnt_o,
    output logic [PID_W-1:0]  winner_o,
    output logic              valid_o
);

    logic [PID_W-1:0]  winner_s;
    logic              found_s;
    logic [NPORTS-1:0] rot_s;
    int                idx_s;

    // Walk the priority order from lowest to highest so the nearest requester
    // to ptr_i is the last one written and therefore the winner.
    always_comb begin
        winner_s = PID_W'(0);
        found_s  = 1'b0;
        rot_s    = {NPORTS{1'b0}};
        idx_s    = 0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            idx_s    = (int'(ptr_i) + k) % NPORTS;
            rot_s    = req_i >> idx_s;
            winner_s = rot_s[0] ? PID_W'(idx_s) : winner_s;
            found_s  = found_s | rot_s[0];
        end
    end

    assign winner_o = winner_s;
    assign valid_o  = found_s;
    assign gnt_o    = found_s ? (NPORTS'(1) << winner_s) : {NPORTS{1'b0}};

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin access controller sharing one synchronous RAM port among
// NPORTS requesters. One access per cycle; a read granted in cycle N has
// its data on rdata with rvalid in cycle N+2.
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   bus       requester bus (slave side): req/we/addr/wdata in, gnt/rvalid/rdata out
//   ram_csn   RAM chip select, active low (registered)
//   ram_rwn   RAM 1 = read / 0 = write (registered)
//   ram_addr  RAM address (registered)
//   ram_din   RAM write data (registered)
//   ram_dout  RAM read data, valid the cycle after the read edge
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      bus,
    output logic              ram_csn,
    output logic              ram_rwn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [NPORTS-1:0] pick_gnt_s;
    logic [PID_W-1:0]  pick_win_s;
    logic              pick_vld_s;
    logic              grant_s;
    logic [NPORTS-1:0] gnt_s;
    logic [NPORTS-1:0] we_rot_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic [PID_W-1:0]  ptr_q,    ptr_d;
    logic              csn_q,    csn_d;
    logic              rwn_q,    rwn_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] din_q,    din_d;
    rsp_t              s1_q,     s1_d;
    logic [NPORTS-1:0] rvalid_q, rvalid_d;

    rr_picker #(.NPORTS(NPORTS)) u_picker (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .gnt_o    (pick_gnt_s),
        .winner_o (pick_win_s),
        .valid_o  (pick_vld_s)
    );

    // Grant qualification and selection of the winning port's command.
    // Reset blocks grants so nothing is accepted that the pipeline would drop.
    always_comb begin
        grant_s     = pick_vld_s & ~rst;
        gnt_s       = grant_s ? pick_gnt_s : {NPORTS{1'b0}};
        we_rot_s    = bus.we >> pick_win_s;
        sel_we_s    = we_rot_s[0];
        sel_addr_s  = bus.addr[pick_win_s*ADDR_W +: ADDR_W];
        sel_wdata_s = bus.wdata[pick_win_s*DATA_W +: DATA_W];
    end

    // Next state: pointer advance, command stage and response pipeline.
    // Stage 1 is the RAM command cycle; the one-hot rvalid register is stage 2.
    always_comb begin
        ptr_d    = ptr_q;
        csn_d    = 1'b1;
        rwn_d    = 1'b1;
        addr_d   = addr_q;
        din_d    = din_q;
        s1_d     = '{vld: 1'b0, id: PID_W'(0)};
        rvalid_d = {NPORTS{1'b0}};
        if (grant_s) begin
            ptr_d    = rr_next(pick_win_s, NPORTS);
            csn_d    = 1'b0;
            rwn_d    = ~sel_we_s;
            addr_d   = sel_addr_s;
            din_d    = sel_wdata_s;
            s1_d.vld = ~sel_we_s;
            s1_d.id  = pick_win_s;
        end else begin
            ptr_d = ptr_q;
        end
        if (s1_q.vld) begin
            rvalid_d = NPORTS'(1) << s1_q.id;
        end else begin
            rvalid_d = {NPORTS{1'b0}};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= PID_W'(0);
            csn_q    <= 1'b1;
            rwn_q    <= 1'b1;
            addr_q   <= {ADDR_W{1'b0}};
            din_q    <= {DATA_W{1'b0}};
            s1_q     <= '{vld: 1'b0, id: PID_W'(0)};
            rvalid_q <= {NPORTS{1'b0}};
        end else begin
            ptr_q    <= ptr_d;
            csn_q    <= csn_d;
            rwn_q    <= rwn_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            s1_q     <= s1_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.gnt    = gnt_s;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = ram_dout;
    assign ram_csn    = csn_q;
    assign ram_rwn    = rwn_q;
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed scenarios followed by randomized traffic on a 2-port ram_arbiter
// driving a behavioural 16x4 RAM. A request-level model (round-robin search,
// memory array, queue of expected read responses) predicts every output each
// cycle; directed scenarios add literal expectations on top.
module tb_ram_arbiter;

    localparam int NP = 2;
    localparam int AW = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          ram_csn, ram_rwn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    ram_arbiter_if #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_csn  (ram_csn),
        .ram_rwn  (ram_rwn),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Behavioural ram16x4: write or read capture at the rising edge.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (!ram_csn) begin
            if (!ram_rwn) ram_mem[ram_addr] <= ram_din;
            else          ram_dout <= ram_mem[ram_addr];
        end
    end

    // Stimulus for the coming cycle.
    logic          d_rst;
    logic [NP-1:0] d_req, d_we;
    logic [AW-1:0] d_addr  [NP];
    logic [DW-1:0] d_wdata [NP];

    // Outputs sampled mid-cycle.
    logic [NP-1:0] s_gnt, s_rvalid;
    logic [DW-1:0] s_rdata, s_din;
    logic [AW-1:0] s_addr;
    logic          s_csn, s_rwn;

    // Reference model.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } rsp_e;
    rsp_e          q[$];
    int            ptr_m;
    logic [DW-1:0] mem_m [16];
    logic          exp_csn, exp_rwn;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Predict this cycle's outputs, compare, then advance across the edge.
    task automatic model_cycle();
        int            w;
        logic [NP-1:0] eg, erv;
        logic [DW-1:0] ed;
        w = -1;
        if (!d_rst) begin
            for (int k = 0; k < NP; k++) begin
                int p;
                p = (ptr_m + k) % NP;
                if (w < 0 && d_req[p]) w = p;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("gnt", 32'(s_gnt), 32'(eg));
        erv = '0;
        ed  = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].port] = 1'b1;
            ed = q[0].data;
            void'(q.pop_front());
        end
        check("rvalid", 32'(s_rvalid), 32'(erv));
        if (erv != '0) check("rdata", 32'(s_rdata), 32'(ed));
        check("ram_csn", 32'(s_csn), 32'(exp_csn));
        check("ram_rwn", 32'(s_rwn), 32'(exp_rwn));
        check("ram_addr", 32'(s_addr), 32'(exp_addr));
        check("ram_din", 32'(s_din), 32'(exp_din));
        if (d_rst) begin
            ptr_m = 0; exp_csn = 1'b1; exp_rwn = 1'b1; exp_addr = '0; exp_din = '0;
            q.delete();
        end else if (w >= 0) begin
            exp_csn  = 1'b0;
            exp_rwn  = ~d_we[w];
            exp_addr = d_addr[w];
            exp_din  = d_wdata[w];
            if (d_we[w]) mem_m[d_addr[w]] = d_wdata[w];
            else q.push_back('{cyc + 2, w, mem_m[d_addr[w]]});
            ptr_m = (w + 1) % NP;
        end else begin
            exp_csn = 1'b1;
            exp_rwn = 1'b1;
        end
    endtask

    // One clock cycle: drive after the edge, sample and check mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
        rst       = d_rst;
        bus.req   = d_req;
        bus.we    = d_we;
        for (int p = 0; p < NP; p++) begin
            bus.addr[p*AW +: AW]  = d_addr[p];
            bus.wdata[p*DW +: DW] = d_wdata[p];
        end
        #4;
        cyc++;
        s_gnt = bus.gnt; s_rvalid = bus.rvalid; s_rdata = bus.rdata;
        s_csn = ram_csn; s_rwn = ram_rwn; s_addr = ram_addr; s_din = ram_din;
        model_cycle();
    endtask

    task automatic set_port(input int p, input bit r, input bit w, input int a, input int d);
        d_req[p]   = r;
        d_we[p]    = w;
        d_addr[p]  = AW'(a);
        d_wdata[p] = DW'(d);
    endtask

    task automatic idle(input int n);
        d_req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic          pv  [NP];
    logic          pwe [NP];
    logic [AW-1:0] pa  [NP];
    logic [DW-1:0] pd  [NP];

    initial begin
        ptr_m = 0; exp_csn = 1'b1; exp_rwn = 1'b1; exp_addr = '0; exp_din = '0;
        d_rst = 1'b1; d_req = '0; d_we = '0;
        for (int p = 0; p < NP; p++) begin d_addr[p] = '0; d_wdata[p] = '0; end
        rst = 1'b1; bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);

        // Reset held with every port requesting.
        d_req = '1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_gnt", 32'(s_gnt), 32'h0);
            check("rst_rvalid", 32'(s_rvalid), 32'h0);
            check("rst_csn", 32'(s_csn), 32'h1);
            check("rst_rwn", 32'(s_rwn), 32'h1);
            check("rst_addr", 32'(s_addr), 32'h0);
            check("rst_din", 32'(s_din), 32'h0);
        end
        d_rst = 1'b0;

        // Single port: write addr 3 = 0xA, then read it back.
        d_req = '0;
        set_port(0, 1, 1, 3, 'hA);
        step();  check("single_wr_gnt", 32'(s_gnt), 32'h1);
        idle(1); check("single_wr_csn_lo", 32'(s_csn), 32'h0);
        idle(1); check("single_wr_csn_hi", 32'(s_csn), 32'h1);
        set_port(0, 1, 0, 3, 0);
        step();  check("single_rd_gnt", 32'(s_gnt), 32'h1);
        idle(1); check("single_rd_csn_lo", 32'(s_csn), 32'h0);
        idle(1);
        check("single_rd_rvalid", 32'(s_rvalid), 32'h1);
        check("single_rd_rdata", 32'(s_rdata), 32'hA);
        check("single_rd_csn_hi", 32'(s_csn), 32'h1);

        // Preload addr 1 = 0x1 (port 0) and addr 2 = 0x2 (port 1).
        d_req = '0;
        set_port(0, 1, 1, 1, 1); step(); d_req = '0;
        set_port(1, 1, 1, 2, 2); step();

        // Contention: both ports read continuously for four grants.
        for (int i = 0; i < 6; i++) begin
            set_port(0, i < 4, 0, 1, 0);
            set_port(1, i < 4, 0, 2, 0);
            step();
            if (i < 4) check("cont_gnt", 32'(s_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i >= 2) begin
                check("cont_rvalid", 32'(s_rvalid), (i % 2 == 0) ? 32'h1 : 32'h2);
                check("cont_rdata", 32'(s_rdata), (i % 2 == 0) ? 32'h1 : 32'h2);
            end
        end

        // Back-to-back: port 1 writes addr 5 = 0x6, port 0 reads it next cycle.
        d_req = '0;
        set_port(1, 1, 1, 5, 6); step(); check("b2b_wr_gnt", 32'(s_gnt), 32'h2);
        d_req = '0;
        set_port(0, 1, 0, 5, 0); step(); check("b2b_rd_gnt", 32'(s_gnt), 32'h1);
        idle(1);
        idle(1);
        check("b2b_rvalid", 32'(s_rvalid), 32'h1);
        check("b2b_rdata", 32'(s_rdata), 32'h6);

        // Reset mid-read, port 1 read in flight.
        d_req = '0;
        set_port(1, 1, 0, 2, 0); step(); check("rstrd1_gnt", 32'(s_gnt), 32'h2);
        d_rst = 1'b1; d_req = '1; step(); check("rstrd1_gnt_rst", 32'(s_gnt), 32'h0);
        d_rst = 1'b0;
        set_port(0, 1, 0, 1, 0); set_port(1, 1, 0, 2, 0); step();
        check("rstrd1_rvalid", 32'(s_rvalid), 32'h0);
        check("rstrd1_csn", 32'(s_csn), 32'h1);
        check("rstrd1_next_gnt", 32'(s_gnt), 32'h1);
        d_req = 2'b10; step(); check("rstrd1_gnt2", 32'(s_gnt), 32'h2);
        idle(3);

        // Reset mid-read, port 0 read in flight: pointer must return to port 0.
        d_req = '0;
        set_port(0, 1, 0, 1, 0); step(); check("rstrd0_gnt", 32'(s_gnt), 32'h1);
        d_rst = 1'b1; d_req = '1; step();
        d_rst = 1'b0;
        set_port(0, 1, 0, 1, 0); set_port(1, 1, 0, 2, 0); step();
        check("rstrd0_rvalid", 32'(s_rvalid), 32'h0);
        check("rstrd0_next_gnt", 32'(s_gnt), 32'h1);
        d_req = 2'b10; step(); check("rstrd0_gnt2", 32'(s_gnt), 32'h2);
        idle(3);

        // Idle for 20 cycles, then read addr 3.
        d_req = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_csn", 32'(s_csn), 32'h1);
        end
        set_port(0, 1, 0, 3, 0); step(); check("idle_rd_gnt", 32'(s_gnt), 32'h1);
        idle(2);
        check("idle_rvalid", 32'(s_rvalid), 32'h1);
        check("idle_rdata", 32'(s_rdata), 32'hA);

        // Fill every address so random reads have defined contents.
        for (int a = 0; a < 16; a++) begin
            d_req = '0;
            set_port(0, 1, 1, a, a ^ 5);
            step();
        end

        // Randomized traffic; each port holds its command until granted.
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0; pwe[p] = 1'b0; pa[p] = '0; pd[p] = '0;
        end
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pv[p] || s_gnt[p]) begin
                    pv[p]  = ($urandom_range(0, 3) != 0);
                    pwe[p] = 1'($urandom_range(0, 1));
                    pa[p]  = AW'($urandom_range(0, 7));
                    pd[p]  = DW'($urandom_range(0, 15));
                end
                set_port(p, pv[p], pwe[p], int'(pa[p]), int'(pd[p]));
            end
            step();
        end
        idle(4);
        check("drain_empty", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
